combat_unit: RTL and testbench

// - Parametrised lane unit, for either army: deploy on purchase, march, fight with attack cooldown, die, respawn-ready.
// - Instantiated N times under the battlefield top; the top computes enemyFront and issues moveSCEN/damageSCEN.
// - Adds to the prior unit: direction, attack range, cooldown, goal detection, death hold time and purchase handshake.

---
 rtl/combat_pkg.sv | 42 ++++
 rtl/combat_unit.sv | 177 +++++++++++++++++
 tb/tb_combat_unit.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/combat_pkg.sv
// Shared encodings and the unit stat table for the lane combat units.
package combat_pkg;

  localparam int STAT_W = 8;

  localparam logic [1:0] TYPE_NONE = 2'b00;
  localparam logic [1:0] TYPE_T1   = 2'b01;
  localparam logic [1:0] TYPE_T2   = 2'b10;
  localparam logic [1:0] TYPE_T3   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DEPLOY = 2'd1,
    ST_ALIVE  = 2'd2,
    ST_DYING  = 2'd3
  } unit_state_e;

  typedef struct packed {
    logic [STAT_W-1:0] health;
    logic [STAT_W-1:0] power;
  } unit_stats_t;

  // typeSel is {SW1,SW2,SW3}; anything that is not exactly one-hot decodes to none.
  function automatic logic [1:0] decode_type(input logic [2:0] sel);
    case (sel)
      3'b100:  decode_type = TYPE_T1;
      3'b010:  decode_type = TYPE_T2;
      3'b001:  decode_type = TYPE_T3;
      default: decode_type = TYPE_NONE;
    endcase
  endfunction

  function automatic unit_stats_t stat_lookup(input logic [1:0] unit_type);
    case (unit_type)
      TYPE_T1: stat_lookup = '{health: 8'd255, power: 8'd32};
      TYPE_T2: stat_lookup = '{health: 8'd255, power: 8'd64};
      TYPE_T3: stat_lookup = '{health: 8'd255, power: 8'd128};
      default: stat_lookup = '{health: 8'd0,   power: 8'd0};
    endcase
  endfunction

endpackage

// File: rtl/combat_unit.sv
// One lane unit: purchase handshake, deploy, march toward the goal, fight with a
// strike cooldown, take damage, and hold in DYING before becoming purchasable again.
module combat_unit
  import combat_pkg::*;
#(
  parameter int POS_W     = 9,
  parameter int HP_W      = 8,
  parameter int DMG_W     = 8,
  parameter int MARCH_DIR = 0,
  parameter int SPAWN_POS = 511,
  parameter int GOAL_POS  = 0,
  parameter int RANGE     = 0,
  parameter int ATK_CD    = 2,
  parameter int DEATH_CYC = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             moveSCEN,
  input  logic             damageSCEN,
  input  logic [DMG_W-1:0] damageIn,
  input  logic [2:0]       typeSel,
  input  logic             purchase,
  input  logic             enemyValid,
  input  logic [POS_W-1:0] enemyFront,
  output logic             purchaseAck,
  output logic [POS_W-1:0] position,
  output logic [DMG_W-1:0] damageOut,
  output logic             atkPulse,
  output logic             goalReached,
  output logic             alive,
  output logic [1:0]       unitType
);

  localparam int CD_W  = (ATK_CD > 0) ? $clog2(ATK_CD + 1) : 1;
  localparam int DC_W  = (DEATH_CYC > 1) ? $clog2(DEATH_CYC + 1) : 1;
  localparam int CMP_W = (DMG_W > HP_W) ? DMG_W : HP_W;

  unit_state_e      state_r;
  logic [HP_W-1:0]  health_r;
  logic [DMG_W-1:0] power_r;
  logic [CD_W-1:0]  cd_r;
  logic [DC_W-1:0]  death_cnt_r;
  logic [1:0]       pend_type_r;
  logic             purchase_ack_r;
  logic [POS_W-1:0] position_r;
  logic [DMG_W-1:0] damage_out_r;
  logic             atk_pulse_r;
  logic             goal_reached_r;
  logic             alive_r;
  logic [1:0]       unit_type_r;

  logic [1:0]       sel_type_s;
  logic             engage_s;
  logic             lethal_s;
  logic [POS_W-1:0] step_pos_s;
  unit_stats_t      stats_s;

  assign sel_type_s = decode_type(typeSel);
  assign stats_s    = stat_lookup(pend_type_r);
  assign lethal_s   = CMP_W'(damageIn) >= CMP_W'(health_r);

  // Engage test and next march position; compared one bit wider so RANGE cannot wrap.
  always_comb begin
    engage_s   = 1'b0;
    step_pos_s = position_r;
    if (MARCH_DIR == 0) begin
      step_pos_s = position_r - POS_W'(1);
      engage_s   = enemyValid &&
                   (({1'b0, enemyFront} + (POS_W+1)'(RANGE)) >= {1'b0, position_r});
    end else begin
      step_pos_s = position_r + POS_W'(1);
      engage_s   = enemyValid &&
                   (({1'b0, position_r} + (POS_W+1)'(RANGE)) >= {1'b0, enemyFront});
    end
  end

  // Unit lifecycle FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      health_r       <= '0;
      power_r        <= '0;
      cd_r           <= '0;
      death_cnt_r    <= '0;
      pend_type_r    <= TYPE_NONE;
      purchase_ack_r <= 1'b0;
      position_r     <= '1;
      damage_out_r   <= '0;
      atk_pulse_r    <= 1'b0;
      goal_reached_r <= 1'b0;
      alive_r        <= 1'b0;
      unit_type_r    <= TYPE_NONE;
    end else begin
      purchase_ack_r <= 1'b0;
      atk_pulse_r    <= 1'b0;
      goal_reached_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (purchase && (sel_type_s != TYPE_NONE)) begin
            purchase_ack_r <= 1'b1;
            pend_type_r    <= sel_type_s;
            state_r        <= ST_DEPLOY;
          end
        end
        ST_DEPLOY: begin
          health_r     <= HP_W'(stats_s.health);
          power_r      <= DMG_W'(stats_s.power);
          position_r   <= POS_W'(SPAWN_POS);
          unit_type_r  <= pend_type_r;
          cd_r         <= '0;
          damage_out_r <= '0;
          alive_r      <= 1'b1;
          state_r      <= ST_ALIVE;
        end
        ST_ALIVE: begin
          // Damage resolves first; a lethal hit swallows any same-cycle move or strike.
          if (damageSCEN && lethal_s) begin
            health_r     <= '0;
            unit_type_r  <= TYPE_NONE;
            damage_out_r <= '0;
            position_r   <= '1;
            alive_r      <= 1'b0;
            death_cnt_r  <= '0;
            state_r      <= ST_DYING;
          end else begin
            if (damageSCEN) begin
              health_r <= health_r - HP_W'(damageIn);
            end
            if (moveSCEN) begin
              if (!engage_s) begin
                damage_out_r <= '0;
                if (step_pos_s == POS_W'(GOAL_POS)) begin
                  goal_reached_r <= 1'b1;
                  position_r     <= '1;
                  health_r       <= '0;
                  unit_type_r    <= TYPE_NONE;
                  alive_r        <= 1'b0;
                  state_r        <= ST_IDLE;
                end else begin
                  position_r <= step_pos_s;
                end
              end else if (cd_r == '0) begin
                damage_out_r <= power_r;
                atk_pulse_r  <= 1'b1;
                cd_r         <= CD_W'(ATK_CD);
              end else begin
                damage_out_r <= '0;
                cd_r         <= cd_r - CD_W'(1);
              end
            end
          end
        end
        ST_DYING: begin
          if (death_cnt_r == DC_W'(DEATH_CYC - 1)) begin
            state_r <= ST_IDLE;
          end else begin
            death_cnt_r <= death_cnt_r + DC_W'(1);
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          position_r <= '1;
          alive_r    <= 1'b0;
        end
      endcase
    end
  end

  assign purchaseAck = purchase_ack_r;
  assign position    = position_r;
  assign damageOut   = damage_out_r;
  assign atkPulse    = atk_pulse_r;
  assign goalReached = goal_reached_r;
  assign alive       = alive_r;
  assign unitType    = unit_type_r;

endmodule

// File: tb/tb_combat_unit.sv
// Scoreboard bench for combat_unit: expected output vectors are queued as stimulus
// is driven and compared against the registered outputs one cycle later.
module tb_combat_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       moveSCEN = 1'b0;
  logic       damageSCEN = 1'b0;
  logic [7:0] damageIn = 8'd0;
  logic [2:0] typeSel = 3'b000;
  logic       purchase = 1'b0;
  logic       enemyValid = 1'b0;
  logic [8:0] enemyFront = 9'd0;

  logic       purchaseAck;
  logic [8:0] position;
  logic [7:0] damageOut;
  logic       atkPulse;
  logic       goalReached;
  logic       alive;
  logic [1:0] unitType;

  // {purchaseAck, position, damageOut, atkPulse, goalReached, alive, unitType}
  typedef struct {
    string       name;
    logic [22:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  wire [22:0] obs = {purchaseAck, position, damageOut, atkPulse, goalReached, alive, unitType};

  always #5 clk = ~clk;

  combat_unit dut (
    .clk        (clk),
    .reset      (reset),
    .moveSCEN   (moveSCEN),
    .damageSCEN (damageSCEN),
    .damageIn   (damageIn),
    .typeSel    (typeSel),
    .purchase   (purchase),
    .enemyValid (enemyValid),
    .enemyFront (enemyFront),
    .purchaseAck(purchaseAck),
    .position   (position),
    .damageOut  (damageOut),
    .atkPulse   (atkPulse),
    .goalReached(goalReached),
    .alive      (alive),
    .unitType   (unitType)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1;
    exp_q.push_back('{"reset", {1'b0, 9'h1FF, 8'd0, 1'b0, 1'b0, 1'b0, 2'b00}});
    tick();
    e = exp_q.pop_front(); n_vec++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.v); end
    reset = 1'b0;
  endtask

  task automatic test_purchase_strike();
    exp_t e;
    purchase = 1'b1; typeSel = 3'b010;
    exp_q.push_back('{"t2_ack", {1'b1, 9'h1FF, 8'd0, 1'b0, 1'b0, 1'b0, 2'b00}});
    tick();
    e = exp_q.pop_front(); n_vec++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.v); end
    purchase = 1'b0; typeSel = 3'b000;
    exp_q.push_back('{"t2_alive", {1'b0, 9'd511, 8'd0, 1'b0, 1'b0, 1'b1, 2'b10}});
    tick();
    e = exp_q.pop_front(); n_vec++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.v); end
    enemyValid = 1'b1; enemyFront = 9'd511; moveSCEN = 1'b1;
    exp_q.push_back('{"t2_strike", {1'b0, 9'd511, 8'd64, 1'b1, 1'b0, 1'b1, 2'b10}});
    tick();
    e = exp_q.pop_front(); n_vec++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.v); end
    moveSCEN = 1'b0;
    exp_q.push_back('{"t2_hold", {1'b0, 9'd511, 8'd64, 1'b0, 1'b0, 1'b1, 2'b10}});
    tick();
    e = exp_q.pop_front(); n_vec++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.v); end
    reset = 1'b1;
    exp_q.push_back('{"reset_alive", {1'b0, 9'h1FF, 8'd0, 1'b0, 1'b0, 1'b0, 2'b00}});
    tick();
    e = exp_q.pop_front(); n_vec++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.v); end
    reset = 1'b0; enemyValid = 1'b0;
  endtask

  task automatic test_bad_purchase();
    exp_t e;
    logic [2:0] sels [4];
    sels = '{3'b110, 3'b000, 3'b111, 3'b011};
    purchase = 1'b1;
    for (int i = 0; i < 4; i++) begin
      typeSel = sels[i];
      exp_q.push_back('{"bad_sel", {1'b0, 9'h1FF, 8'd0, 1'b0, 1'b0, 1'b0, 2'b00}});
      tick();
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e.v) begin n_err++; $display("FAIL %s(%b): observed %h expected %h", e.name, sels[i], obs, e.v); end
    end
    purchase = 1'b0; typeSel = 3'b000;
    exp_q.push_back('{"bad_idle", {1'b0, 9'h1FF, 8'd0, 1'b0, 1'b0, 1'b0, 2'b00}});
    tick();
    e = exp_q.pop_front(); n_vec++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.v); end
  endtask

  task automatic test_march_goal();
    exp_t e;
    int   pos_m;
    logic mv;
    purchase = 1'b1; typeSel = 3'b001;
    exp_q.push_back('{"t3_ack", {1'b1, 9'h1FF, 8'd0, 1'b0, 1'b0, 1'b0, 2'b00}});
    tick();
    e = exp_q.pop_front(); n_vec++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.v); end
    purchase = 1'b0; typeSel = 3'b000;
    exp_q.push_back('{"t3_alive", {1'b0, 9'd511, 8'd0, 1'b0, 1'b0, 1'b1, 2'b11}});
    tick();
    e = exp_q.pop_front(); n_vec++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.v); end
    enemyValid = 1'b0;
    pos_m = 511;
    for (int i = 0; i < 2000 && pos_m != 0; i++) begin
      mv = ($urandom_range(0, 3) != 0);
      moveSCEN = mv;
      if (mv) pos_m--;
      if (pos_m == 0)
        exp_q.push_back('{"march_goal", {1'b0, 9'h1FF, 8'd0, 1'b0, 1'b1, 1'b0, 2'b00}});
      else
        exp_q.push_back('{"march", {1'b0, 9'(pos_m), 8'd0, 1'b0, 1'b0, 1'b1, 2'b11}});
      tick();
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e.v) begin n_err++; $display("FAIL %s@%0d: observed %h expected %h", e.name, pos_m, obs, e.v); end
    end
    n_vec++;
    if (pos_m != 0) begin n_err++; $display("FAIL march_budget: observed pos %0d expected 0", pos_m); end
    moveSCEN = 1'b0;
    exp_q.push_back('{"goal_clear", {1'b0, 9'h1FF, 8'd0, 1'b0, 1'b0, 1'b0, 2'b00}});
    tick();
    e = exp_q.pop_front(); n_vec++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.v); end
    // unit is back in IDLE, so a fresh purchase must be accepted
    purchase = 1'b1; typeSel = 3'b100;
    exp_q.push_back('{"t1_ack", {1'b1, 9'h1FF, 8'd0, 1'b0, 1'b0, 1'b0, 2'b00}});
    tick();
    e = exp_q.pop_front(); n_vec++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.v); end
    purchase = 1'b0; typeSel = 3'b000;
    exp_q.push_back('{"t1_alive", {1'b0, 9'd511, 8'd0, 1'b0, 1'b0, 1'b1, 2'b01}});
    tick();
    e = exp_q.pop_front(); n_vec++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.v); end
  endtask

  task automatic test_cooldown();
    exp_t e;
    int   mv_t  [5];
    int   dmg_t [5];
    int   atk_t [5];
    mv_t  = '{1, 0, 1, 1, 1};
    dmg_t = '{32, 32, 0, 0, 32};
    atk_t = '{1, 0, 0, 0, 1};
    enemyValid = 1'b1; enemyFront = 9'd500; moveSCEN = 1'b1;
    for (int p = 510; p >= 500; p--) begin
      exp_q.push_back('{"approach", {1'b0, 9'(p), 8'd0, 1'b0, 1'b0, 1'b1, 2'b01}});
      tick();
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e.v) begin n_err++; $display("FAIL %s@%0d: observed %h expected %h", e.name, p, obs, e.v); end
    end
    for (int i = 0; i < 5; i++) begin
      moveSCEN = (mv_t[i] != 0);
      exp_q.push_back('{"cooldown", {1'b0, 9'd500, 8'(dmg_t[i]), 1'(atk_t[i]), 1'b0, 1'b1, 2'b01}});
      tick();
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e.v) begin n_err++; $display("FAIL %s[%0d]: observed %h expected %h", e.name, i, obs, e.v); end
    end
    moveSCEN = 1'b0; enemyValid = 1'b0;
  endtask

  task automatic test_damage_death();
    exp_t e;
    int   hits [3];
    hits = '{100, 100, 54};
    damageSCEN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      damageIn = 8'(hits[i]);
      exp_q.push_back('{"survive", {1'b0, 9'd500, 8'd32, 1'b0, 1'b0, 1'b1, 2'b01}});
      tick();
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e.v) begin n_err++; $display("FAIL %s[%0d]: observed %h expected %h", e.name, i, obs, e.v); end
    end
    // health is now exactly 1
    damageIn = 8'd1;
    exp_q.push_back('{"lethal_eq", {1'b0, 9'h1FF, 8'd0, 1'b0, 1'b0, 1'b0, 2'b00}});
    tick();
    e = exp_q.pop_front(); n_vec++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.v); end
    damageSCEN = 1'b0; damageIn = 8'd0;
    purchase = 1'b1; typeSel = 3'b010;
    for (int k = 1; k <= 11; k++) begin
      if (k == 11)
        exp_q.push_back('{"respawn_ack", {1'b1, 9'h1FF, 8'd0, 1'b0, 1'b0, 1'b0, 2'b00}});
      else
        exp_q.push_back('{"dying_no_ack", {1'b0, 9'h1FF, 8'd0, 1'b0, 1'b0, 1'b0, 2'b00}});
      tick();
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e.v) begin n_err++; $display("FAIL %s@%0d: observed %h expected %h", e.name, k, obs, e.v); end
    end
    purchase = 1'b0; typeSel = 3'b000;
    exp_q.push_back('{"respawn_alive", {1'b0, 9'd511, 8'd0, 1'b0, 1'b0, 1'b1, 2'b10}});
    tick();
    e = exp_q.pop_front(); n_vec++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.v); end
  endtask

  task automatic test_same_cycle();
    exp_t e;
    // fresh unit with cd 0 and an engaged enemy: a strike would fire if not suppressed
    enemyValid = 1'b1; enemyFront = 9'd511;
    moveSCEN = 1'b1; damageSCEN = 1'b1; damageIn = 8'd255;
    exp_q.push_back('{"lethal_move", {1'b0, 9'h1FF, 8'd0, 1'b0, 1'b0, 1'b0, 2'b00}});
    tick();
    e = exp_q.pop_front(); n_vec++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.v); end
    moveSCEN = 1'b0; damageSCEN = 1'b0; damageIn = 8'd0; enemyValid = 1'b0;
    exp_q.push_back('{"dead_quiet", {1'b0, 9'h1FF, 8'd0, 1'b0, 1'b0, 1'b0, 2'b00}});
    tick();
    e = exp_q.pop_front(); n_vec++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.v); end
  endtask

  initial begin
    test_reset();
    test_purchase_strike();
    test_bad_purchase();
    test_march_goal();
    test_cooldown();
    test_damage_death();
    test_same_cycle();
    test_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
